stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer: the steering counterpart of the commonlib N-way mux. Each accepted input word goes to the output lane chosen by its select field. Every lane has its own buffered stage with an independent valid/ready handshake, so a stalled lane never blocks traffic addressed to other lanes. It sits between a single producer and N consumer streams, for example a bank or port fan-out.

## Interface
- N, default 2: number of output lanes; legal range 2..16.
- WIDTH, default 1: data width in bits.
- SEL_W, derived as max(1, $clog2(N)): select width.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- I_data  input  WIDTH  input word.
- I_sel  input  SEL_W  destination lane index.
- I_valid  input  1  input word present.
- I_ready  output  1  block accepts input this cycle.
- O_data  output  N x WIDTH  per-lane data (unpacked array [N-1:0]).
- O_valid  output  N  per-lane data present.
- O_ready  input  N  per-lane consumer ready.
- ERR  output  1  sticky flag: an out-of-range I_sel was accepted.

## Operation
- Transfer rules:
  - Input transfer occurs when I_valid && I_ready at a rising edge.
  - Lane k transfer occurs when O_valid[k] && O_ready[k].
- Each lane is a FIFO slot with state EMPTY, ONE or TWO. TWO is reachable only with skid enabled; see Configuration.
- I_ready depends on I_sel:
  - In range (I_sel < N): I_ready follows the lane-accept rule in Configuration.
  - Out of range (I_sel >= N): I_ready=1. The word is accepted and dropped, and ERR is set.
- ERR clears only on RESET.
- Lane state transitions, where "push" means an input transfer targets this lane and "pop" means a lane transfer:
  - EMPTY + push → ONE.
  - ONE + push + pop → ONE, holding the new word.
  - ONE + push → TWO.
  - ONE + pop → EMPTY.
  - TWO + pop → ONE, with the skid word moving to the head.
  - TWO + push + pop → TWO.
- Ordering is FIFO per lane. There is no ordering guarantee across lanes.
- O_valid[k] = (state_k != EMPTY). O_data[k] is the head entry.
- While O_valid[k]=1 and O_ready[k]=0, O_data[k] is held stable.
- Data is never duplicated across lanes or lost. The only exception is the out-of-range drop.

## Timing
- Latency: a word accepted at edge t appears on O_valid/O_data of its lane after edge t, one cycle later, provided the lane was empty.
- Throughput: 1 word/cycle per lane when the consumer holds O_ready=1.
- Reset values: all lanes EMPTY, O_valid=0, O_data=0, ERR=0.
- I_ready=0 during any cycle in which RESET=1.
- RESET mid-operation: buffered words are discarded at the reset edge. No transfer counts on that edge.
- A push and pop on the same lane in the same cycle is legal and does not change occupancy (ONE→ONE, TWO→TWO).
- Pushes and pops on different lanes in the same cycle are independent.
- I_data and I_sel may change while I_valid=0 with no effect.

## Configuration
- Macro: STREAM_DEMUX_SKID_EN.
- Undefined (default):
  - Each lane holds one entry.
  - I_ready = (state[I_sel]==EMPTY) || O_ready[I_sel].
  - This is a combinational O_ready→I_ready path.
- Defined:
  - Each lane holds two entries (skid).
  - I_ready = (state[I_sel] != TWO), which is independent of O_ready and so breaks the combinational path.
  - Full throughput is still achieved with one cycle of consumer back-pressure slack.

## Structure
- Package stream_demux_pkg holds:
  - typedef enum slot_state_t {EMPTY, ONE, TWO};
  - function sel_width(n).
- Sub-module stream_demux_lane: one-lane buffer with push/pop/data/valid/ready. It is instantiated N times by a generate loop.
- The top level contains only select decode, I_ready selection, and the ERR register.

## Test plan
- Reset, then a single word: N=4, WIDTH=8. Send 0xA5 with I_sel=2 and O_ready=all 1 → O_valid=4'b0100 and O_data[2]=0xA5 one cycle later. Other lanes stay invalid.
- Stalled lane isolation: hold O_ready[1]=0 and fill lane 1. Then send 0x11 to lane 0 → accepted. I_ready=0 only while I_sel=1. Lane 1 data is held stable.
- Back-to-back streaming: send 0x00..0x0F to lane 3 with O_ready[3]=1 → 16 words out in order at one per cycle, with no bubbles.
- Skid behaviour (macro defined): O_ready[0]=0, push 0x01 and 0x02 → both accepted, then I_ready=0. Release O_ready → 0x01 then 0x02 appear.
- Out-of-range select: N=3, send with I_sel=3 → I_ready=1, word dropped, ERR=1 the next cycle and sticky until RESET.
- Reset mid-operation: with lanes 0 and 2 holding data, assert RESET for 1 cycle → O_valid=0, ERR=0. The next push behaves as after a cold reset.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream_demux block.
package stream_demux_pkg;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} slot_state_t;

  // Select width: max(1, clog2(n)).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_lane.sv
// One output lane of stream_demux: a one-entry buffer, or two entries
// (head + skid) when STREAM_DEMUX_SKID_EN is defined.
module stream_demux_lane
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             accept,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop;
`ifdef STREAM_DEMUX_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
`endif

  // Lane accept rule seen by the top-level I_ready selection.
  always_comb begin
`ifdef STREAM_DEMUX_SKID_EN
    accept = (state_q != TWO);
`else
    accept = (state_q == EMPTY) || out_ready;
`endif
  end

  // Occupancy and data next-state from push/pop.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
`ifdef STREAM_DEMUX_SKID_EN
    skid_d  = skid_q;
`endif
    pop     = (state_q != EMPTY) && out_ready;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
`ifdef STREAM_DEMUX_SKID_EN
          skid_d  = push_data;
          state_d = TWO;
`else
          head_d  = push_data;
`endif
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
`ifdef STREAM_DEMUX_SKID_EN
      TWO: begin
        // Skid word moves to the head; a simultaneous push refills the skid.
        if (pop) begin
          head_d = skid_q;
          if (push) begin
            skid_d = push_data;
          end else begin
            state_d = ONE;
          end
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  // Lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
`ifdef STREAM_DEMUX_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
`ifdef STREAM_DEMUX_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  // Head entry drives the lane output.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = head_q;
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer. Define STREAM_DEMUX_SKID_EN for
// two-entry lanes, which removes the combinational O_ready->I_ready path.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned N     = 2,
  parameter  int unsigned WIDTH = 1,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_data,
  input  logic [SEL_W-1:0] I_sel,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O_data [N-1:0],
  output logic [N-1:0]     O_valid,
  input  logic [N-1:0]     O_ready,
  output logic             ERR
);

  logic [N-1:0] sel_hit;
  logic [N-1:0] lane_accept;
  logic [N-1:0] push;
  logic         in_range;
  logic         xfer;
  logic         err_q, err_d;

  // One-hot select decode; codes >= N hit no lane.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel_hit[k] = (I_sel == SEL_W'(k));
    end
    in_range = |sel_hit;
  end

  // Out-of-range words are always accepted (and dropped).
  always_comb begin
    I_ready = !RESET && (!in_range || |(sel_hit & lane_accept));
  end

  // Steer the accepted word and track out-of-range acceptance.
  always_comb begin
    xfer  = I_valid && I_ready;
    push  = xfer ? sel_hit : '0;
    err_d = err_q | (xfer && !in_range);
  end

  // Sticky error flag.
  always_ff @(posedge CLK) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign ERR = err_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    stream_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (CLK),
      .rst       (RESET),
      .push      (push[g]),
      .push_data (I_data),
      .accept    (lane_accept[g]),
      .out_valid (O_valid[g]),
      .out_data  (O_data[g]),
      .out_ready (O_ready[g])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomized bench for stream_demux against a per-lane queue model.
module tb_stream_demux;

`ifdef STREAM_DEMUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-lane instance
  logic       rst, iv, irdy, err;
  logic [1:0] isel;
  logic [7:0] idata;
  logic [7:0] od [3:0];
  logic [3:0] ov, ordy;

  // 3-lane instance (out-of-range select)
  logic       r3, v3, irdy3, err3;
  logic [1:0] s3;
  logic [7:0] d3;
  logic [7:0] od3 [2:0];
  logic [2:0] ov3, o3;

  stream_demux #(.N(4), .WIDTH(8)) dut (
    .CLK(clk), .RESET(rst), .I_data(idata), .I_sel(isel), .I_valid(iv),
    .I_ready(irdy), .O_data(od), .O_valid(ov), .O_ready(ordy), .ERR(err)
  );

  stream_demux #(.N(3), .WIDTH(8)) dut3 (
    .CLK(clk), .RESET(r3), .I_data(d3), .I_sel(s3), .I_valid(v3),
    .I_ready(irdy3), .O_data(od3), .O_valid(ov3), .O_ready(o3), .ERR(err3)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mq [0:3][$];
  int         pops [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] ordy_i, output logic acc);
    logic pred;
    @(negedge clk);
    rst = r; iv = v; isel = s; idata = d; ordy = ordy_i;
    #1;
    if (r) pred = 1'b0;
    else begin
`ifdef STREAM_DEMUX_SKID_EN
      pred = (mq[s].size() < DEPTH);
`else
      pred = (mq[s].size() == 0) || ordy_i[s];
`endif
    end
    check_eq("i_ready", irdy, pred);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("o_valid%0d", k), ov[k], mq[k].size() != 0);
      if (mq[k].size() != 0) check_eq($sformatf("o_data%0d", k), od[k], mq[k][0]);
    end
    check_eq("err4", err, 1'b0);
    acc = v && pred;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r) mq[k].delete();
      else if (mq[k].size() != 0 && ordy_i[k]) begin
        void'(mq[k].pop_front());
        pops[k]++;
      end
    end
    if (!r && acc) mq[s].push_back(d);
  endtask

  initial begin
    logic a;
    int   p0;
    rst = 1'b1; iv = 1'b0; isel = '0; idata = '0; ordy = '1;
    r3 = 1'b1; v3 = 1'b0; s3 = '0; d3 = '0; o3 = '1;
    for (int k = 0; k < 4; k++) pops[k] = 0;

    // Reset
    step(1'b1, 1'b1, 2'd0, 8'h00, 4'hF, a);
    step(1'b1, 1'b0, 2'd0, 8'h00, 4'hF, a);
    #1;
    check_eq("rst_ov", ov, 4'b0000);
    check_eq("rst_err", err, 1'b0);
    for (int k = 0; k < 4; k++) check_eq($sformatf("rst_od%0d", k), od[k], 8'h00);
    r3 = 1'b0;

    // Single word latency
    step(1'b0, 1'b1, 2'd2, 8'hA5, 4'hF, a);
    #1;
    check_eq("single_ov", ov, 4'b0100);
    check_eq("single_od2", od[2], 8'hA5);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);

    // Stalled lane isolation
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 2'd1, 8'h20 + 8'(i), 4'b1101, a);
      check_eq("stall_fill_acc", a, 1'b1);
    end
    step(1'b0, 1'b1, 2'd1, 8'h30, 4'b1101, a);
    check_eq("stall_full_acc", a, 1'b0);
    step(1'b0, 1'b1, 2'd0, 8'h11, 4'b1101, a);
    check_eq("other_lane_acc", a, 1'b1);
    #1;
    check_eq("stall_hold_od1", od[1], 8'h20);
    repeat (3) step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);

    // Back-to-back streaming on lane 3
    p0 = pops[3];
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 2'd3, 8'(i), 4'hF, a);
      check_eq("stream_acc", a, 1'b1);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);
    check_eq("stream_count", pops[3] - p0, 16);

`ifdef STREAM_DEMUX_SKID_EN
    // Skid: two words absorbed under back-pressure, then drained in order
    step(1'b0, 1'b1, 2'd0, 8'h01, 4'h0, a);
    check_eq("skid_acc1", a, 1'b1);
    step(1'b0, 1'b1, 2'd0, 8'h02, 4'h0, a);
    check_eq("skid_acc2", a, 1'b1);
    step(1'b0, 1'b1, 2'd0, 8'h03, 4'h0, a);
    check_eq("skid_full", a, 1'b0);
    #1;
    check_eq("skid_head", od[0], 8'h01);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);
    #1;
    check_eq("skid_second", od[0], 8'h02);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'($urandom), 4'($urandom), a);
    end
    repeat (3) step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);

    // Reset mid-operation
    step(1'b0, 1'b1, 2'd0, 8'hC0, 4'h0, a);
    step(1'b0, 1'b1, 2'd2, 8'hC2, 4'h0, a);
    step(1'b1, 1'b0, 2'd0, 8'h00, 4'h0, a);
    #1;
    check_eq("midrst_ov", ov, 4'b0000);
    check_eq("midrst_err", err, 1'b0);
    step(1'b0, 1'b1, 2'd1, 8'h5A, 4'hF, a);
    #1;
    check_eq("postrst_ov", ov, 4'b0010);
    check_eq("postrst_od1", od[1], 8'h5A);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'hF, a);

    // Out-of-range select on the 3-lane instance
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd3; d3 = 8'h77; o3 = 3'b111;
    #1;
    check_eq("oor_ready", irdy3, 1'b1);
    check_eq("oor_err_before", err3, 1'b0);
    @(posedge clk); #1;
    check_eq("oor_err", err3, 1'b1);
    check_eq("oor_drop_ov", ov3, 3'b000);
    @(negedge clk);
    v3 = 1'b1; s3 = 2'd2; d3 = 8'h42;
    @(posedge clk); #1;
    check_eq("n3_lane2_ov", ov3, 3'b100);
    check_eq("n3_lane2_od", od3[2], 8'h42);
    @(negedge clk);
    v3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("oor_sticky", err3, 1'b1);
    @(negedge clk);
    r3 = 1'b1;
    #1;
    check_eq("n3_rst_ready", irdy3, 1'b0);
    @(posedge clk); #1;
    check_eq("oor_cleared", err3, 1'b0);
    check_eq("n3_rst_ov", ov3, 3'b000);
    @(negedge clk);
    r3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
